ram_xfer_ctrl: RTL and testbench



---
 rtl/ram_xfer_pkg.sv | 14 +
 rtl/ram_xfer_wstage.sv | 81 ++++++++
 rtl/ram_xfer_ctrl.sv | 144 ++++++++++++++
 tb/tb_ram_xfer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_xfer_pkg.sv
// Shared types and default sizing for the RAM-to-RAM transfer controller.
package ram_xfer_pkg;

    localparam int RX_DEPTH = 16;
    localparam int RX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/ram_xfer_wstage.sv
// Registered write stage feeding the destination RAM's synchronous write port.
// Optional build macro XFER_CHECKSUM_EN adds a running modular sum of every
// word that is actually presented to the destination.
module ram_xfer_wstage
    import ram_xfer_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH,
    parameter int AW    = $clog2(RX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic [AW-1:0]    cap_addr,
    input  logic [WIDTH-1:0] cap_data,
`ifdef XFER_CHECKSUM_EN
    input  logic             clr,
    output logic [WIDTH-1:0] checksum,
`endif
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data
);

    logic             valid_q, valid_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Capture a word when asked; address/data hold otherwise so the bus stays quiet.
    always_comb begin
        valid_d = cap_en;
        addr_d  = addr_q;
        data_d  = data_q;
        if (cap_en) begin
            addr_d = cap_addr;
            data_d = cap_data;
        end
    end

    // Stage registers; async reset kills a pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wr_en   = valid_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;

`ifdef XFER_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    // Sum words as they commit, so the value is final once the last write lands.
    always_comb begin
        csum_d = csum_q;
        if (clr) begin
            csum_d = '0;
        end else if (valid_q) begin
            csum_d = csum_q + data_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: rtl/ram_xfer_ctrl.sv
// Block copy from a source RAM (async read) to a destination RAM (sync write),
// one word per clock after a single-cycle fill of the write stage.
// Optional build macro XFER_CHECKSUM_EN exposes a checksum of the copied words.
//
// state | meaning
// IDLE  | waiting for start; read address holds its last value
// XFER  | reading source words, one per clock, into the write stage
// DRAIN | last captured word is being written
// DONE  | one-cycle completion pulse (held one extra silent cycle for len=0)
module ram_xfer_ctrl
    import ram_xfer_pkg::*;
#(
    parameter int DEPTH     = RX_DEPTH,
    parameter int WIDTH     = RX_WIDTH,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] src_base,
    input  logic [DEPTH_LOG-1:0] dst_base,
    input  logic [DEPTH_LOG:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH_LOG-1:0] src_addr_rd,
    input  logic [WIDTH-1:0]     src_data_rd,
    output logic                 dst_wr_en,
    output logic [DEPTH_LOG-1:0] dst_addr_wr,
`ifdef XFER_CHECKSUM_EN
    output logic [WIDTH-1:0]     checksum,
`endif
    output logic [WIDTH-1:0]     dst_data_wr
);

    xfer_state_e          state_q, state_d;
    logic [DEPTH_LOG-1:0] src_base_q, src_base_d;
    logic [DEPTH_LOG-1:0] dst_base_q, dst_base_d;
    logic [DEPTH_LOG-1:0] len_m1_q, len_m1_d;
    logic [DEPTH_LOG-1:0] rd_idx_q, rd_idx_d;
    logic                 zl_q, zl_d;
    logic                 cap_en;
    logic                 clr;
    logic [DEPTH_LOG-1:0] cap_addr;

    // Next-state, operand latching and read indexing.
    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        len_m1_d   = len_m1_q;
        rd_idx_d   = rd_idx_q;
        zl_d       = zl_q;
        cap_en     = 1'b0;
        clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (len != '0) begin
                        src_base_d = src_base;
                        dst_base_d = dst_base;
                        len_m1_d   = DEPTH_LOG'(len - 1'b1);
                        rd_idx_d   = '0;
                        state_d    = XFER;
                    end else begin
                        zl_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                cap_en = 1'b1;
                if (rd_idx_q == len_m1_q) begin
                    state_d = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + DEPTH_LOG'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                // A zero-length request spends one quiet cycle here so its
                // pulse lands one cycle after acceptance, like the fill cycle.
                if (zl_q) begin
                    zl_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_m1_q   <= '0;
            rd_idx_q   <= '0;
            zl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            len_m1_q   <= len_m1_d;
            rd_idx_q   <= rd_idx_d;
            zl_q       <= zl_d;
        end
    end

    assign src_addr_rd = src_base_q + rd_idx_q;
    assign cap_addr    = dst_base_q + rd_idx_q;
    assign busy        = (state_q == XFER) || (state_q == DRAIN);
    assign done        = (state_q == DONE) && !zl_q;

    ram_xfer_wstage #(
        .WIDTH (WIDTH),
        .AW    (DEPTH_LOG)
    ) u_wstage (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .cap_addr (cap_addr),
        .cap_data (src_data_rd),
`ifdef XFER_CHECKSUM_EN
        .clr      (clr),
        .checksum (checksum),
`endif
        .wr_en    (dst_wr_en),
        .wr_addr  (dst_addr_wr),
        .wr_data  (dst_data_wr)
    );

`ifndef XFER_CHECKSUM_EN
    logic unused_clr;
    assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_ram_xfer_ctrl.sv
// Bench for ram_xfer_ctrl: source RAM and destination RAM modelled as arrays,
// expected timing and contents derived from the transfer rules.
module tb_ram_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] src_base = '0;
    logic [3:0] dst_base = '0;
    logic [4:0] len = '0;
    logic       busy;
    logic       done;
    logic [3:0] src_addr_rd;
    logic [7:0] src_data_rd;
    logic       dst_wr_en;
    logic [3:0] dst_addr_wr;
    logic [7:0] dst_data_wr;
`ifdef XFER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] src_mem [16];
    logic [7:0] dst_mem [16] = '{default: 8'h00};
    int         wr_count = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    assign src_data_rd = src_mem[src_addr_rd];

    always @(posedge clk) begin
        if (dst_wr_en) begin
            dst_mem[dst_addr_wr] <= dst_data_wr;
            wr_count <= wr_count + 1;
        end
    end

    ram_xfer_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .src_addr_rd (src_addr_rd),
        .src_data_rd (src_data_rd),
        .dst_wr_en   (dst_wr_en),
        .dst_addr_wr (dst_addr_wr),
`ifdef XFER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .dst_data_wr (dst_data_wr)
    );

    task automatic fill_src_random();
        for (int i = 0; i < 16; i++) src_mem[i] = 8'($urandom_range(0, 255));
    endtask

    // One transfer, checked cycle by cycle against the documented timeline.
    task automatic do_xfer(input int sb, input int db, input int ln, input int busy_start_at, input string tag);
        logic [7:0] exp_mem [16];
        logic [7:0] sum;
        logic       exp_busy, exp_done, exp_we;
        int         nwr0;
        sum = 8'h00;
        for (int i = 0; i < 16; i++) exp_mem[i] = dst_mem[i];
        for (int k = 0; k < ln; k++) begin
            exp_mem[(db + k) % 16] = src_mem[(sb + k) % 16];
            sum = 8'(sum + src_mem[(sb + k) % 16]);
        end
        @(negedge clk);
        nwr0 = wr_count;
        src_base = 4'(sb);
        dst_base = 4'(db);
        len = 5'(ln);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n <= ln + 3; n++) begin
            @(negedge clk);
            exp_busy = (ln != 0) && (n <= ln);
            exp_done = (ln == 0) ? (n == 1) : (n == ln + 1);
            exp_we   = (n >= 1) && (n <= ln);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, n, busy, exp_busy);
            end
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, n, done, exp_done);
            end
            vectors++;
            if (dst_wr_en !== exp_we) begin
                miscompares++;
                $display("FAIL %s wr_en cyc=%0d got=%b exp=%b", tag, n, dst_wr_en, exp_we);
            end
            if (exp_we) begin
                vectors++;
                if (dst_addr_wr !== 4'((db + n - 1) % 16) || dst_data_wr !== src_mem[(sb + n - 1) % 16]) begin
                    miscompares++;
                    $display("FAIL %s wr cyc=%0d got=%0d:%h exp=%0d:%h", tag, n, dst_addr_wr, dst_data_wr,
                             (db + n - 1) % 16, src_mem[(sb + n - 1) % 16]);
                end
            end
            if (ln != 0 && n < ln) begin
                vectors++;
                if (src_addr_rd !== 4'((sb + n) % 16)) begin
                    miscompares++;
                    $display("FAIL %s rd_addr cyc=%0d got=%0d exp=%0d", tag, n, src_addr_rd, (sb + n) % 16);
                end
            end
`ifdef XFER_CHECKSUM_EN
            if (n == 0) begin
                vectors++;
                if (checksum !== 8'h00) begin
                    miscompares++;
                    $display("FAIL %s csum_clear got=%h exp=00", tag, checksum);
                end
            end
            if (exp_done) begin
                vectors++;
                if (checksum !== sum) begin
                    miscompares++;
                    $display("FAIL %s csum got=%h exp=%h", tag, checksum, sum);
                end
            end
`endif
            if (n == busy_start_at) begin
                start = 1'b1;
                src_base = 4'($urandom_range(0, 15));
                dst_base = 4'($urandom_range(0, 15));
                len = 5'($urandom_range(1, 16));
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (wr_count - nwr0 != ln) begin
            miscompares++;
            $display("FAIL %s write_count got=%0d exp=%0d", tag, wr_count - nwr0, ln);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (dst_mem[i] !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL %s dst_mem[%0d] got=%h exp=%h", tag, i, dst_mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, dst_wr_en, src_addr_rd, dst_addr_wr, dst_data_wr} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset outputs got=%b/%b/%b/%0d/%0d/%h exp=all zero", busy, done, dst_wr_en,
                     src_addr_rd, dst_addr_wr, dst_data_wr);
        end
`ifdef XFER_CHECKSUM_EN
        vectors++;
        if (checksum !== 8'h00) begin
            miscompares++;
            $display("FAIL reset checksum got=%h exp=00", checksum);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i + 16);
        do_xfer(0, 0, 4, -1, "basic");
    endtask

    task automatic test_wrap();
        fill_src_random();
        do_xfer(14, 15, 4, -1, "wrap");
    endtask

    task automatic test_zero_len();
        do_xfer(5, 9, 0, -1, "zero_len");
    endtask

    task automatic test_busy_start();
        fill_src_random();
        do_xfer(3, 7, 16, 5, "full_busy_start");
    endtask

    // Reset lands during the third write of an eight-word transfer.
    task automatic test_reset_mid();
        logic [7:0] exp_mem [16];
        int         nwr0;
        fill_src_random();
        for (int i = 0; i < 16; i++) exp_mem[i] = dst_mem[i];
        for (int k = 0; k < 2; k++) exp_mem[(10 + k) % 16] = src_mem[(2 + k) % 16];
        @(negedge clk);
        nwr0 = wr_count;
        src_base = 4'd2;
        dst_base = 4'd10;
        len = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (dst_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid third_write_pending got=%b exp=1", dst_wr_en);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({dst_wr_en, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid async_drop got=%b%b%b exp=000", dst_wr_en, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            vectors++;
            if ({dst_wr_en, busy, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_mid quiet cyc=%0d got=%b%b%b exp=000", n, dst_wr_en, busy, done);
            end
        end
        vectors++;
        if (wr_count - nwr0 != 2) begin
            miscompares++;
            $display("FAIL rst_mid write_count got=%0d exp=2", wr_count - nwr0);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (dst_mem[i] !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL rst_mid dst_mem[%0d] got=%h exp=%h", i, dst_mem[i], exp_mem[i]);
            end
        end
        fill_src_random();
        do_xfer(6, 1, 5, -1, "after_rst");
    endtask

    task automatic test_checksum();
`ifdef XFER_CHECKSUM_EN
        fill_src_random();
        src_mem[4] = 8'hFF;
        src_mem[5] = 8'h02;
        src_mem[6] = 8'h10;
        do_xfer(4, 9, 3, -1, "csum");
        vectors++;
        if (checksum !== 8'h11) begin
            miscompares++;
            $display("FAIL csum hold got=%h exp=11", checksum);
        end
        do_xfer(0, 0, 2, -1, "csum_next");
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            fill_src_random();
            do_xfer($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 16), -1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src_mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_busy_start();
        test_reset_mid();
        test_checksum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
